uart_cmd_ctrl: RTL
==================

Name: uart_cmd_ctrl

Overview:
- Parametrised UART command controller between the existing byte-level receiver and transmitter and the per-core AXI traffic generators and PMUs.
- Decodes opcode-framed byte commands and drives the generator config, FIFO push, start and PMU select signals. Returns idle status and PMU counters.
- Over the previous controller it adds:
  - generic widths
  - per-core start mask
  - core-index range checking
  - PMU read latency
  - inter-byte timeout
  - an error counter

Parameters:
CORE_COUNT, 16, number of cores/generators (>=1)
AXI_ID_WIDTH, 5, AXI ID width per generator
PMU_ADDR_WIDTH, 5, PMU metric select width
PMU_DATA_WIDTH, 64, PMU counter width (multiple of 8)
PMU_LATENCY, 1, cycles from pmu_addr_o update to valid pmu_data_i (>=1)
TIMEOUT_CYCLES, 1_000_000, idle cycles between argument bytes before abort (>=2)

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
rx_data_i  in  8  received byte
rx_valid_i  in  1  one-cycle strobe, byte valid
tx_data_o  out  8  byte to transmitter
tx_valid_o  out  1  byte valid
tx_ready_i  in  1  transmitter accepts byte
req_depth_o  out  8  global request depth
id_o  out  CORE_COUNT x AXI_ID_WIDTH  per-core AXI ID
axlen_o  out  CORE_COUNT x 8  per-core AXLEN
write_o  out  CORE_COUNT  per-core 1=write, 0=read
fifo_push_o  out  CORE_COUNT  one-cycle push strobe
start_o  out  CORE_COUNT  one-cycle start strobe
idle_i  in  CORE_COUNT  generator idle flags
pmu_addr_o  out  CORE_COUNT x PMU_ADDR_WIDTH  per-core metric select
pmu_data_i  in  CORE_COUNT x PMU_DATA_WIDTH  per-core counter value
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Derived widths:
  - CIB = max(1, ceil(clog2(CORE_COUNT)/8))
  - IDB = ceil(AXI_ID_WIDTH/8)
  - MB = ceil(CORE_COUNT/8)
  - PB = PMU_DATA_WIDTH/8
- Multi-byte fields are sent LSB byte first. Excess bits are discarded, except that the core index is compared at full CIB*8 width.
- Reset: every output is 0, state is IDLE, err_cnt is 0. Reset mid-command discards the partial frame immediately.
- States: IDLE, RX_ARGS, EXEC, PMU_WAIT, TX.
- IDLE + rx_valid_i:
  - Known opcode -> RX_ARGS, or EXEC if the command has no arguments.
  - Unknown opcode -> TX with the single byte 0xEE, and err_cnt increments.
- RX_ARGS:
  - Each strobe stores one byte.
  - After the last byte -> EXEC.
  - If TIMEOUT_CYCLES cycles pass with no strobe -> TX 0xEE, err_cnt increments.
- EXEC lasts exactly 1 cycle, then goes to TX or PMU_WAIT.
- TX:
  - tx_data_o is stable while tx_valid_o && !tx_ready_i.
  - The next byte is presented no earlier than the cycle after acceptance.
  - After the last byte is accepted -> IDLE.
- Bytes arriving in EXEC, PMU_WAIT or TX are dropped, and each drop increments err_cnt.
- Commands (ACK = opcode|0x80):
  - 0x01 TEST: 1 arg X; response is (X+1) mod 256.
  - 0x02 SET_DEPTH: 1 arg. req_depth_o is updated in EXEC. Response is ACK.
  - 0x03 READ / 0x04 WRITE: args are CIB core bytes, IDB id bytes, 1 axlen byte.
    - In EXEC, if core < CORE_COUNT: id_o[core], axlen_o[core] and write_o[core] are updated and fifo_push_o[core] pulses in the same cycle, so the registered values are visible with the push. Response is ACK.
    - Otherwise there is no push, the response is 0xEE and err_cnt increments.
  - 0x05 IDLE_STATUS: no args. idle_i is snapshotted in EXEC. Response is MB bytes; unused MSBs are 0.
  - 0x06 START: MB mask bytes. In EXEC, start_o[c] pulses for every set bit c < CORE_COUNT; higher bits are ignored. Response is ACK.
  - 0x07 READ_PMU: args are CIB core bytes, 1 metric byte.
    - Invalid core -> 0xEE, err_cnt increments.
    - Valid core: pmu_addr_o[core] is updated in EXEC, then PMU_WAIT lasts PMU_LATENCY cycles, then pmu_data_i[core] is captured. Response is PB bytes.
    - pmu_addr_o holds its value afterwards.
  - 0x08 STATUS: no args. Response is the err_cnt byte.
- err_cnt: 8 bits, saturates at 255.
  - Cleared when the STATUS byte is accepted.
  - An error event in the same cycle as the clear leaves err_cnt at 1.
- A back-to-back opcode is accepted in the first IDLE cycle after TX completes.

Optional Feature:
- Macro UART_CMD_CTRL_CHECKSUM_EN.
- Defined: every response, including 0xEE responses, is followed by one extra byte equal to the XOR of all preceding response bytes of that command. TX ends after that byte is accepted.
- Undefined: no checksum byte; response lengths are exactly as listed above.

Test Plan:
- Send 0x01, 0x41 -> single tx byte 0x42; 0x01, 0xFF -> 0x00; busy_o low afterwards.
- Send 0x04, 0x03, 0x11, 0x07 -> fifo_push_o = 16'h0008 for exactly 1 cycle, with id_o[3]=0x11, axlen_o[3]=7, write_o[3]=1 in that cycle. Then tx 0x84.
- Send 0x03, 0x14 (core 20 with CORE_COUNT=16), 0x01, 0x00 -> no push, tx 0xEE. Then 0x08 -> 0x01, and a repeat 0x08 -> 0x00.
- Send 0x06, 0x05, 0x80 -> start_o = 16'h8005 pulsed for 1 cycle, tx 0x86. With idle_i = 16'hA5C3, send 0x05 -> tx 0xC3 then 0xA5.
- Send 0x07, 0x02, 0x09 with pmu_data_i[2] = 64'h0123_4567_89AB_CDEF valid PMU_LATENCY cycles after pmu_addr_o[2]=9 -> tx EF CD AB 89 67 45 23 01. Hold tx_ready_i low 10 cycles mid-stream -> data stable, no byte lost.
- Send 0x04, 0x01 then silence for TIMEOUT_CYCLES -> tx 0xEE, return to IDLE. Assert arstn_i mid-frame -> all outputs 0, next 0x01, 0x10 -> 0x11.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: UART byte-command decoder driving per-core AXI traffic generators and PMU reads.
// Define UART_CMD_CTRL_CHECKSUM_EN to append an XOR checksum byte to every response.
module uart_cmd_ctrl #(
  parameter int CORE_COUNT     = 16,
  parameter int AXI_ID_WIDTH   = 5,
  parameter int PMU_ADDR_WIDTH = 5,
  parameter int PMU_DATA_WIDTH = 64,
  parameter int PMU_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                      clk_i,
  input  logic                                      arstn_i,
  input  logic [7:0]                                rx_data_i,
  input  logic                                      rx_valid_i,
  output logic [7:0]                                tx_data_o,
  output logic                                      tx_valid_o,
  input  logic                                      tx_ready_i,
  output logic [7:0]                                req_depth_o,
  output logic [CORE_COUNT-1:0][AXI_ID_WIDTH-1:0]   id_o,
  output logic [CORE_COUNT-1:0][7:0]                axlen_o,
  output logic [CORE_COUNT-1:0]                     write_o,
  output logic [CORE_COUNT-1:0]                     fifo_push_o,
  output logic [CORE_COUNT-1:0]                     start_o,
  input  logic [CORE_COUNT-1:0]                     idle_i,
  output logic [CORE_COUNT-1:0][PMU_ADDR_WIDTH-1:0] pmu_addr_o,
  input  logic [CORE_COUNT-1:0][PMU_DATA_WIDTH-1:0] pmu_data_i,
  output logic                                      busy_o
);
  localparam int CLG  = CORE_COUNT > 1 ? $clog2(CORE_COUNT) : 0;
  localparam int CIB  = CLG > 8 ? (CLG + 7) / 8 : 1;
  localparam int IDB  = (AXI_ID_WIDTH + 7) / 8;
  localparam int MB   = (CORE_COUNT + 7) / 8;
  localparam int PB   = PMU_DATA_WIDTH / 8;
  localparam int ARW  = CIB + IDB + 1;
  localparam int AMAX = ARW > MB ? ARW : MB;
`ifdef UART_CMD_CTRL_CHECKSUM_EN
  localparam int CSB  = 1;
`else
  localparam int CSB  = 0;
`endif
  localparam int RMAX = (PB > MB ? PB : MB) + CSB;
  localparam int ACW  = $clog2(AMAX + 1);
  localparam int RCW  = $clog2(RMAX + 1);
  localparam int CSW  = CLG > 0 ? CLG : 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES);
  localparam int LW   = PMU_LATENCY > 1 ? $clog2(PMU_LATENCY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RX_ARGS, S_EXEC, S_PMU_WAIT, S_TX} state_t;

  state_t                                    state_q;
  logic [7:0]                                op_q, err_q, err_d, depth_q;
  logic [AMAX*8-1:0]                         args_q;
  logic [ACW-1:0]                            acnt_q;
  logic [TW-1:0]                             tmo_q;
  logic [LW-1:0]                             lat_q;
  logic [RMAX*8-1:0]                         resp_q, rd, resp_ld;
  logic [RCW-1:0]                            rlen_q, rn, rlen_ld;
  logic                                      clr_pend_q, tx_valid_q;
  logic [CORE_COUNT-1:0][AXI_ID_WIDTH-1:0]   id_q;
  logic [CORE_COUNT-1:0][7:0]                len_q;
  logic [CORE_COUNT-1:0]                     wr_q, push_q, start_q;
  logic [CORE_COUNT-1:0][PMU_ADDR_WIDTH-1:0] pmu_addr_q;
  logic [CIB*8-1:0]                          core_idx;
  logic [CSW-1:0]                            core_sel;
  logic                                      core_ok, core_op, tmo_hit, lat_hit, bad_op, ld, drop, ev_cmd;
  logic [8:0]                                err_sum;

  function automatic logic known(input logic [7:0] op);
    return op >= 8'h01 && op <= 8'h08;
  endfunction

  function automatic logic [ACW-1:0] nargs(input logic [7:0] op);
    return (op == 8'h01 || op == 8'h02) ? ACW'(1) :
           (op == 8'h03 || op == 8'h04) ? ACW'(ARW) :
           op == 8'h06 ? ACW'(MB) :
           op == 8'h07 ? ACW'(CIB + 1) : '0;
  endfunction

  assign core_idx = args_q[CIB*8-1:0];
  assign core_sel = core_idx[CSW-1:0];
  assign core_ok  = 32'(core_idx) < 32'(CORE_COUNT);
  assign core_op  = op_q == 8'h03 || op_q == 8'h04 || op_q == 8'h07;
  assign tmo_hit  = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign lat_hit  = lat_q == LW'(PMU_LATENCY - 1);
  assign bad_op   = (state_q == S_IDLE && rx_valid_i && !known(rx_data_i)) ||
                    (state_q == S_RX_ARGS && !rx_valid_i && tmo_hit);
  assign ld       = bad_op || (state_q == S_EXEC && !(op_q == 8'h07 && core_ok)) ||
                    (state_q == S_PMU_WAIT && lat_hit);
  assign drop     = rx_valid_i && (state_q == S_EXEC || state_q == S_PMU_WAIT || state_q == S_TX);
  assign ev_cmd   = bad_op || (state_q == S_EXEC && core_op && !core_ok);
  assign err_sum  = {1'b0, err_q} + 9'(ev_cmd) + 9'(drop);
  // the clear takes effect on the first (status) byte; a coincident error survives as a count of one
  assign err_d    = (tx_valid_q && tx_ready_i && clr_pend_q) ? {7'b0, ev_cmd | drop} :
                    err_sum[8] ? 8'hFF : err_sum[7:0];

  always_comb begin
    rd = '0;
    rn = RCW'(1);
    if (state_q == S_PMU_WAIT) begin
      rd[PMU_DATA_WIDTH-1:0] = pmu_data_i[core_sel];
      rn = RCW'(PB);
    end else if (state_q == S_EXEC && op_q == 8'h05) begin
      rd[CORE_COUNT-1:0] = idle_i;
      rn = RCW'(MB);
    end else if (state_q == S_EXEC) begin
      rd[7:0] = op_q == 8'h01 ? args_q[7:0] + 8'd1 :
                op_q == 8'h08 ? err_q :
                (core_op && !core_ok) ? 8'hEE : op_q | 8'h80;
    end else begin
      rd[7:0] = 8'hEE;
    end
  end

`ifdef UART_CMD_CTRL_CHECKSUM_EN
  logic [7:0] cs;
  // bytes above the response length are zero, so XOR over the whole buffer is the checksum
  always_comb begin
    cs = '0;
    for (int i = 0; i < RMAX; i++) cs = cs ^ rd[i*8 +: 8];
  end
  assign resp_ld = rd | ((RMAX*8)'(cs) << {rn, 3'b000});
  assign rlen_ld = rn + 1'b1;
`else
  assign resp_ld = rd;
  assign rlen_ld = rn;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      err_q      <= '0;
      depth_q    <= '0;
      args_q     <= '0;
      acnt_q     <= '0;
      tmo_q      <= '0;
      lat_q      <= '0;
      resp_q     <= '0;
      rlen_q     <= '0;
      clr_pend_q <= 1'b0;
      tx_valid_q <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      wr_q       <= '0;
      push_q     <= '0;
      start_q    <= '0;
      pmu_addr_q <= '0;
    end else begin
      push_q  <= '0;
      start_q <= '0;
      err_q   <= err_d;
      case (state_q)
        S_IDLE: if (rx_valid_i && known(rx_data_i)) begin
          op_q    <= rx_data_i;
          acnt_q  <= '0;
          tmo_q   <= '0;
          state_q <= nargs(rx_data_i) == '0 ? S_EXEC : S_RX_ARGS;
        end
        S_RX_ARGS: if (rx_valid_i) begin
          for (int i = 0; i < AMAX; i++) if (acnt_q == ACW'(i)) args_q[i*8 +: 8] <= rx_data_i;
          acnt_q <= acnt_q + 1'b1;
          tmo_q  <= '0;
          if (acnt_q + 1'b1 == nargs(op_q)) state_q <= S_EXEC;
        end else if (!tmo_hit) begin
          tmo_q <= tmo_q + 1'b1;
        end
        S_EXEC: begin
          clr_pend_q <= op_q == 8'h08;
          if (op_q == 8'h02) depth_q <= args_q[7:0];
          if (op_q == 8'h06) start_q <= args_q[CORE_COUNT-1:0];
          if ((op_q == 8'h03 || op_q == 8'h04) && core_ok) begin
            id_q[core_sel]   <= args_q[CIB*8 +: AXI_ID_WIDTH];
            len_q[core_sel]  <= args_q[(CIB+IDB)*8 +: 8];
            wr_q[core_sel]   <= op_q[2];
            push_q[core_sel] <= 1'b1;
          end
          if (op_q == 8'h07 && core_ok) begin
            pmu_addr_q[core_sel] <= PMU_ADDR_WIDTH'(args_q[CIB*8 +: 8]);
            lat_q                <= '0;
            state_q              <= S_PMU_WAIT;
          end
        end
        S_PMU_WAIT: if (!lat_hit) lat_q <= lat_q + 1'b1;
        S_TX: if (tx_ready_i) begin
          resp_q     <= resp_q >> 8;
          rlen_q     <= rlen_q - 1'b1;
          clr_pend_q <= 1'b0;
          if (rlen_q == RCW'(1)) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (ld) begin
        resp_q     <= resp_ld;
        rlen_q     <= rlen_ld;
        tx_valid_q <= 1'b1;
        state_q    <= S_TX;
      end
    end
  end

  assign tx_data_o   = resp_q[7:0];
  assign tx_valid_o  = tx_valid_q;
  assign req_depth_o = depth_q;
  assign id_o        = id_q;
  assign axlen_o     = len_q;
  assign write_o     = wr_q;
  assign fifo_push_o = push_q;
  assign start_o     = start_q;
  assign pmu_addr_o  = pmu_addr_q;
  assign busy_o      = state_q != S_IDLE;
endmodule
